// File: rtl/vending_pkg.sv
// Shared types and constants for the vending payment stage.
// Holds the FSM state encoding, coin codes and the coin-to-cents decode.
package vending_pkg;

  localparam int unsigned CREDIT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StChange
  } state_e;

  localparam logic [1:0] Coin5   = 2'd0;
  localparam logic [1:0] Coin10  = 2'd1;
  localparam logic [1:0] Coin25  = 2'd2;
  localparam logic [1:0] Coin100 = 2'd3;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] val;
    unique case (code)
      Coin5:   val = 8'd5;
      Coin10:  val = 8'd10;
      Coin25:  val = 8'd25;
      default: val = 8'd100;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vending_payment_ctrl_if.sv
// Coin/selection inputs, dispense handshake and refund outputs of the payment stage.
// The master modport is the environment side; the slave modport is the controller.
interface vending_payment_ctrl_if;
  import vending_pkg::*;

  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [CREDIT_W-1:0] sel_price;
  logic                cancel;
  logic                dispense_ack;
  logic                dispense_req;
  logic                payment_ok;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_price, cancel, dispense_ack,
    input  dispense_req, payment_ok, credit, coin_reject, change_valid, change_amt
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_price, cancel, dispense_ack,
    output dispense_req, payment_ok, credit, coin_reject, change_valid, change_amt
  );

endinterface

// File: rtl/vending_timeout_ctr.sv
// Inactivity counter: counts while enabled, clears on demand, flags TIMEOUT_CYCLES-1.
// Holds at terminal count rather than wrapping.
module vending_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != TcVal)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/vending_payment_ctrl.sv
// Payment stage: accumulates coins, latches price, hands off to the dispenser,
// then returns change. Handles cancel and inactivity refund; all outputs registered.
module vending_payment_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned MAX_CREDIT     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  vending_payment_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                vend_q, vend_d;
  logic                coin_reject_q, coin_reject_d;
  logic                change_valid_q, change_valid_d;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                sel_ok;
  logic [CREDIT_W-1:0] remainder;
  logic                activity;
  logic                timeout;

  // 9-bit sum so a large coin on high credit cannot wrap past the limit check
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_type)};
  assign coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_ok    = bus.sel_valid && (bus.sel_price != '0);
  assign remainder = credit_q - price_q;

  vending_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q != StCollect) || activity),
    .en   (state_q == StCollect),
    .tc   (timeout)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    price_d        = price_q;
    change_amt_d   = change_amt_q;
    vend_d         = 1'b0;
    coin_reject_d  = 1'b0;
    change_valid_d = 1'b0;
    activity       = 1'b0;

    case (state_q)
      StIdle: begin
        if (sel_ok) price_d = bus.sel_price;
        if (bus.coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = StCollect;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (bus.cancel || timeout) begin
          state_d        = StChange;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          coin_reject_d  = bus.coin_valid;
        end else if ((price_q != '0) && (credit_q >= price_q)) begin
          // Any coin alongside the hand-off is returned, selection is dropped
          state_d       = StVend;
          vend_d        = 1'b1;
          coin_reject_d = bus.coin_valid;
        end else begin
          if (sel_ok) begin
            price_d  = bus.sel_price;
            activity = 1'b1;
          end
          if (bus.coin_valid) begin
            if (coin_fits) begin
              credit_d = coin_sum[CREDIT_W-1:0];
              activity = 1'b1;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end
      StVend: begin
        vend_d        = 1'b1;
        coin_reject_d = bus.coin_valid;
        if (bus.dispense_ack) begin
          vend_d   = 1'b0;
          credit_d = remainder;
          price_d  = '0;
          if (remainder != '0) begin
            state_d        = StChange;
            change_valid_d = 1'b1;
            change_amt_d   = remainder;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StChange: begin
        credit_d      = '0;
        price_d       = '0;
        state_d       = StIdle;
        coin_reject_d = bus.coin_valid;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      price_q        <= '0;
      change_amt_q   <= '0;
      vend_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      change_amt_q   <= change_amt_d;
      vend_q         <= vend_d;
      coin_reject_q  <= coin_reject_d;
      change_valid_q <= change_valid_d;
    end
  end

  assign bus.dispense_req = vend_q;
  assign bus.payment_ok   = vend_q;
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;

endmodule

// File: tb/tb_vending_payment_ctrl.sv
// Bench for vending_payment_ctrl: directed scenarios then random traffic, every
// output compared each cycle against a cents-level model of the payment rules.
module tb_vending_payment_ctrl;

  localparam int MaxCredit = 200;
  localparam int Timeout   = 8;

  localparam int PIdle    = 0;
  localparam int PCollect = 1;
  localparam int PVend    = 2;
  localparam int PChange  = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  vending_payment_ctrl_if bus ();

  vending_payment_ctrl #(
    .MAX_CREDIT    (MaxCredit),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what the customer-visible outputs should be after each edge
  int m_phase, m_credit, m_price, m_idle, m_camt;
  bit m_rej, m_cv;
  int cents[4];

  task automatic model_reset();
    m_phase = PIdle; m_credit = 0; m_price = 0; m_idle = 0; m_camt = 0;
    m_rej = 0; m_cv = 0;
  endtask

  task automatic model_step(input bit cv, input int ct, input bit sv, input int sp,
                            input bit cn, input bit ak);
    int  val;
    int  rem;
    bit  act;
    val   = cents[ct];
    m_rej = 0;
    m_cv  = 0;
    if (m_phase == PIdle) begin
      if (sv && sp != 0) m_price = sp;
      if (cv) begin
        if (m_credit + val <= MaxCredit) begin
          m_credit += val; m_phase = PCollect; m_idle = 0;
        end else m_rej = 1;
      end
    end else if (m_phase == PCollect) begin
      if (cn || m_idle == Timeout - 1) begin
        m_phase = PChange; m_cv = 1; m_camt = m_credit; m_rej = cv;
      end else if (m_price != 0 && m_credit >= m_price) begin
        m_phase = PVend; m_rej = cv;
      end else begin
        act = 0;
        if (sv && sp != 0) begin m_price = sp; act = 1; end
        if (cv) begin
          if (m_credit + val <= MaxCredit) begin m_credit += val; act = 1; end
          else m_rej = 1;
        end
        m_idle = act ? 0 : m_idle + 1;
      end
    end else if (m_phase == PVend) begin
      m_rej = cv;
      if (ak) begin
        rem      = m_credit - m_price;
        m_credit = rem;
        m_price  = 0;
        if (rem > 0) begin m_phase = PChange; m_cv = 1; m_camt = rem; end
        else m_phase = PIdle;
      end
    end else begin
      m_credit = 0; m_price = 0; m_phase = PIdle; m_rej = cv;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] e_vend;
    e_vend = (m_phase == PVend) ? 8'd1 : 8'd0;
    check("credit", bus.credit, 8'(m_credit));
    check("dispense_req", {7'd0, bus.dispense_req}, e_vend);
    check("payment_ok", {7'd0, bus.payment_ok}, e_vend);
    check("coin_reject", {7'd0, bus.coin_reject}, {7'd0, m_rej});
    check("change_valid", {7'd0, bus.change_valid}, {7'd0, m_cv});
    check("change_amt", bus.change_amt, 8'(m_camt));
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic cyc(input bit cv, input int ct, input bit sv, input int sp,
                     input bit cn, input bit ak);
    bus.coin_valid   = cv;
    bus.coin_type    = 2'(ct);
    bus.sel_valid    = sv;
    bus.sel_price    = 8'(sp);
    bus.cancel       = cn;
    bus.dispense_ack = ak;
    model_step(cv, ct, sv, sp, cn, ak);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int ct);
    cyc(1, ct, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int prices[8];

  initial begin
    cents       = '{5, 10, 25, 100};
    prices      = '{0, 15, 30, 60, 95, 150, 200, 255};
    vectors     = 0;
    miscompares = 0;
    bus.coin_valid = 0; bus.coin_type = 0; bus.sel_valid = 0; bus.sel_price = 0;
    bus.cancel = 0; bus.dispense_ack = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exact-price purchase: 25+25+10 against 60, no change expected
    cyc(0, 0, 1, 60, 0, 0);
    coin(2); coin(2); coin(1);
    idle(1);
    idle(10);              // longer than the timeout: VEND must keep waiting
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    // Overpay 100 for 30: change 70
    cyc(0, 0, 1, 30, 0, 0);
    coin(3);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    // Limit: 150 + 100 rejected, 150 + 25 accepted
    coin(3); coin(2); coin(2);
    coin(3);
    coin(2);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);

    // Cancel with a simultaneous coin
    coin(2); coin(1);
    cyc(1, 0, 0, 0, 1, 0);
    idle(2);

    // Inactivity refund, with a coin partway through restarting the count
    coin(1);
    idle(4);
    coin(0);
    idle(Timeout + 2);

    // Coins rejected while vending, then reset mid-operation
    cyc(0, 0, 1, 20, 0, 0);
    coin(2);
    idle(1);
    coin(3);
    coin(0);
    pulse_reset();
    idle(2);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      cyc(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
          prices[$urandom_range(0, 7)],
          ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0);
      if (n == 400) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_payment_ctrl.md
Name: vending_payment_ctrl

Overview:
- Upstream payment stage of the vending datapath.
- Accumulates inserted coins into a credit register and latches the product price.
- Once credit covers the price, raises dispense_req and payment_ok to the FSM dispense controller and waits for its acknowledge.
- Deducts the price and refunds any remainder; also handles cancel and inactivity timeout.

Parameters:
- MAX_CREDIT, 200, maximum credit in cents. Must be ≤255.
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before an automatic refund. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- coin_valid  input  1  one-cycle strobe: a coin is presented.
- coin_type  input  2  coin value: 0=5, 1=10, 2=25, 3=100 cents.
- sel_valid  input  1  one-cycle strobe: a product is selected.
- sel_price  input  8  price in cents. A value of 0 is ignored.
- cancel  input  1  user cancel request.
- dispense_ack  input  1  dispense controller has dispensed.
- dispense_req  output  1  request to the dispense controller.
- payment_ok  output  1  credit ≥ price. Asserted together with dispense_req.
- credit  output  8  current credit in cents.
- coin_reject  output  1  one-cycle pulse: coin returned.
- change_valid  output  1  one-cycle pulse: change_amt is valid.
- change_amt  output  8  refund or change amount. Holds its last value.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - credit, price, timeout counter and change_amt = 0.
  - dispense_req, payment_ok, coin_reject, change_valid = 0.
- Coin acceptance (IDLE or COLLECT): a coin is accepted iff credit+value ≤ MAX_CREDIT. Compute the sum in 9 bits so it cannot wrap.
  - Accepted: credit updates on the next edge.
  - Not accepted: coin_reject=1 for exactly one cycle and credit is unchanged.
- sel_valid with sel_price≠0 (IDLE or COLLECT): latches price. A later selection overwrites it.
- IDLE:
  - Accepted coin → COLLECT.
  - Selection alone latches price and stays in IDLE.
  - cancel is ignored.
- COLLECT:
  - Timeout counter resets on every accepted coin or selection, otherwise increments.
  - Checks are applied in this priority order:
    1. cancel → CHANGE. A coin in the same cycle is rejected (coin_reject pulse).
    2. Counter reaches TIMEOUT_CYCLES-1 → CHANGE.
    3. price≠0 and credit ≥ price (registered values) → VEND.
  - A coin or selection arriving in the same cycle as the transition to VEND is evaluated from the next cycle.
- VEND:
  - dispense_req=1 and payment_ok=1, both registered and asserted from the first VEND cycle.
  - Coins are rejected. cancel and sel_valid are ignored.
  - On dispense_ack: credit ← credit − price, price ← 0. If the remainder > 0 go to CHANGE, else go to IDLE. dispense_req and payment_ok drop the cycle after the ack.
  - No timeout in VEND: it waits indefinitely.
- CHANGE (one cycle):
  - change_valid=1, change_amt=credit.
  - Next edge: credit ← 0, price ← 0, state → IDLE.
  - Coins presented here are rejected.
- Latency:
  - Coin to credit update: 1 cycle.
  - Credit reaching price to dispense_req: 1 cycle.
  - dispense_ack to change_valid: 1 cycle.
- Reset mid-operation: all state is lost. No refund is produced.
- Outputs are glitch-free: all are driven from registers.

Decomposition:
- Package vending_pkg holds:
  - state encoding IDLE / COLLECT / VEND / CHANGE;
  - coin code constants and a coin_value function (2-bit code → 8-bit cents);
  - CREDIT_W=8.
- One natural sub-module, vending_timeout_ctr: a counter with clear/enable inputs and a terminal-count output.

Test Plan:
- Reset, then insert 25, 25, 10 with price 60 → credit 25, 50, 60; dispense_req and payment_ok go 1 the cycle after credit=60; ack → change_valid with change_amt 0 is not produced, state returns to IDLE.
- Price 30, insert 100 → VEND; ack → change_valid=1 for one cycle with change_amt=70, then credit=0.
- Credit 150 (100+25+25), insert 100 → coin_reject pulse, credit stays 150; insert 25 → credit 175.
- Credit 35, cancel and coin_valid in the same cycle → coin_reject=1 and change_valid=1 with change_amt=35 on the next cycle, then IDLE.
- TIMEOUT_CYCLES=8, insert 10 then stay idle → change_valid with change_amt=10 after 8 cycles; a coin at cycle 5 restarts the count.
- During VEND, pulse rst_n low → all outputs 0 immediately, credit=0; coins in VEND before the reset are rejected.
